vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
//  Downstream consumer of the 640x480 stripe generator's VGA outputs (hsync, vsync, red/green/blue).
//  Measures the sync timing and checks it against nominal 640x480@60 values.
//  Asserts `locked` after LOCK_FRAMES consecutive good frames; accumulates a per-frame pixel checksum.
//  Used in simulation benches and on-board as a self-check on the video path.
// PARAMETERS
//  H_TOTAL     800  clocks per line (leading hsync edge to leading hsync edge)
//  H_SYNC      96   hsync active width, clocks
//  H_ACT_START 144  first active pixel column, counted from the hsync leading edge (hcnt=0)
//  H_ACTIVE    640  active pixels per line
//  V_TOTAL     525  lines per frame (hsync leading edges between vsync leading edges)
//  V_SYNC      2    vsync active width, in lines
//  V_ACT_START 35   first active line, counted from the vsync leading edge (vcnt=0)
//  V_ACTIVE    480  active lines per frame
//  SYNC_POL    0    active level of hsync/vsync (0 = active-low)
//  LOCK_FRAMES 2    consecutive good frames required to assert locked
// PORTS
//  clk25       in   1   pixel clock, 25 MHz
//  clr_n       in   1   asynchronous active-low reset
//  hsync       in   1   horizontal sync from the generator
//  vsync       in   1   vertical sync from the generator
//  red         in   3   pixel red
//  green       in   3   pixel green
//  blue        in   2   pixel blue
//  h_period    out  11  last measured line length, clocks, saturates at 2047
//  h_width     out  11  last measured hsync active width, clocks, saturates
//  v_lines     out  11  last measured lines per frame, saturates
//  v_width     out  11  last measured vsync width, lines
//  frame_sum   out  24  checksum of the last complete frame
//  frame_done  out  1   1-cycle pulse; all measurement outputs updated this cycle
//  frame_err   out  1   1-cycle pulse with frame_done when the frame mismatched
//  locked      out  1   timing lock
// BEHAVIOUR
//  - Reset: all outputs 0; state SEARCH; all counters 0. Reset is legal mid-frame; it takes effect immediately.
//  - Inputs are registered once, together, so sync and pixel stay aligned.
//    A leading edge is when the registered sync is at its active level and the previous sample was not.
//    Output latency from the pin edge to the output is 2 clocks.
//  - hcnt: set to 0 on each hsync leading edge, otherwise +1, saturating at 2047.
//    On each hsync leading edge, h_period <= hcnt+1 (not on the first edge after SEARCH).
//    h_width counts registered hsync active clocks and is latched on the trailing edge.
//  - vcnt: +1 on each hsync leading edge, set to 0 on the vsync leading edge.
//    v_width = number of hsync leading edges seen while vsync is active.
//  - Line check: a sticky line_err is set if any line in the frame has h_period != H_TOTAL or h_width != H_SYNC.
//  - Checksum: when H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE and V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE,
//    sum += {red,green,blue}, where {red,green,blue} is zero-extended and the sum wraps mod 2^24.
//  - FSM:
//    SEARCH -> MEASURE on the first vsync leading edge. This clears sum, line_err and good_cnt.
//      No frame_done is issued for this first, partial frame.
//    MEASURE/LOCKED: each subsequent vsync leading edge ends a frame. On that edge:
//      - frame_done pulses; v_lines, v_width and frame_sum are latched.
//      - The frame is good iff !line_err, v_lines==V_TOTAL and v_width==V_SYNC.
//      - Good: good_cnt++ (saturating). When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1
//        in the same cycle as frame_done.
//      - Bad: frame_err pulses, good_cnt=0, locked=0, next state MEASURE.
//      - sum and line_err are cleared for the next frame, with no gap cycle.
//    Timeout, in any state except SEARCH: no hsync leading edge for 2*H_TOTAL clocks ->
//      SEARCH, locked=0, good_cnt=0. Measurement outputs are held. No frame_done is issued.
//  - Simultaneous hsync and vsync leading edges: the hsync edge is applied first.
//    The line is counted, then vcnt is zeroed.
//  - Overflow: all measurement counters saturate. A saturated value never matches nominal, so that frame is bad.
// TESTING
//  1 Reset held, random sync toggles -> all outputs 0 and locked stays 0 until clr_n rises.
//  2 Nominal generator stream -> first frame_done at the 2nd vsync edge with h_period=800, h_width=96,
//    v_lines=525, v_width=2; locked=1 at the 3rd vsync edge.
//  3 Constant colour 8'hFF over the full active area -> frame_sum=24'hAB5000.
//    All-zero pixels -> frame_sum=0.
//  4 While locked, one line lengthened to 801 clocks -> at that frame's end frame_err=1 and locked=0.
//    locked relocks after 2 further good frames.
//  5 hsync held inactive for 1600 clocks while locked -> SEARCH, locked=0, no frame_done, outputs held.
//  6 clr_n pulsed low mid-frame while locked -> outputs 0 immediately.
//    Relock follows the same timing as scenario 2.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: measures VGA sync timing against nominal values, tracks lock
// and accumulates a per-frame checksum of the active-area pixels.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk25,
    input  logic        clr_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    output logic [10:0] h_period,
    output logic [10:0] h_width,
    output logic [10:0] v_lines,
    output logic [10:0] v_width,
    output logic [23:0] frame_sum,
    output logic        frame_done,
    output logic        frame_err,
    output logic        locked
);
    localparam logic [10:0] HT  = 11'(H_TOTAL);
    localparam logic [10:0] HS  = 11'(H_SYNC);
    localparam logic [10:0] HA0 = 11'(H_ACT_START);
    localparam logic [10:0] HA1 = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] VT  = 11'(V_TOTAL);
    localparam logic [10:0] VS  = 11'(V_SYNC);
    localparam logic [10:0] VA0 = 11'(V_ACT_START);
    localparam logic [10:0] VA1 = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [10:0] TO  = 11'(2 * H_TOTAL);
    localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);
    localparam logic        POL = 1'(SYNC_POL);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nx;

    logic        hs_r, vs_r, hs_p, vs_p;
    logic [7:0]  pix;
    logic [10:0] hcnt, vcnt, hw_cnt, vw_cnt;
    logic [23:0] sum;
    logic        line_err, h_valid;
    logic [3:0]  good_cnt, gc_inc;
    logic        h_act, v_act, h_lead, h_trail, v_lead;
    logic [10:0] hinc, hpos, vinc, vpos;
    logic        line_bad, win, timeout, frame_end, good;

    function automatic logic [10:0] inc(input logic [10:0] v);
        return (&v) ? v : v + 11'd1;
    endfunction

    // hpos/vpos are the positions of the sample currently in hs_r/pix
    always_comb begin
        h_act     = hs_r == POL;
        v_act     = vs_r == POL;
        h_lead    = h_act && hs_p != POL;
        h_trail   = !h_act && hs_p == POL;
        v_lead    = v_act && vs_p != POL;
        hinc      = inc(hcnt);
        hpos      = h_lead ? 11'd0 : hinc;
        vinc      = h_lead ? inc(vcnt) : vcnt;
        vpos      = v_lead ? 11'd0 : vinc;
        line_bad  = h_lead && h_valid && (hinc != HT || h_width != HS);
        win       = hpos >= HA0 && hpos < HA1 && vpos >= VA0 && vpos < VA1;
        timeout   = state != SEARCH && hpos == TO;
        frame_end = state != SEARCH && v_lead && !timeout;
        good      = !(line_err || line_bad) && vinc == VT && vw_cnt == VS;
        gc_inc    = (&good_cnt) ? good_cnt : good_cnt + 4'd1;
    end

    always_comb begin
        state_nx = timeout ? SEARCH :
                   state == SEARCH ? (v_lead ? MEASURE : SEARCH) :
                   !frame_end ? state :
                   !good ? MEASURE :
                   gc_inc >= LF ? LOCKED : state;
    end

    always_ff @(posedge clk25 or negedge clr_n) begin
        if (!clr_n) state <= SEARCH;
        else state <= state_nx;
    end

    always_ff @(posedge clk25 or negedge clr_n) begin
        if (!clr_n) begin
            hs_r       <= ~POL;
            vs_r       <= ~POL;
            hs_p       <= ~POL;
            vs_p       <= ~POL;
            pix        <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            hw_cnt     <= '0;
            vw_cnt     <= '0;
            sum        <= '0;
            line_err   <= 1'b0;
            h_valid    <= 1'b0;
            good_cnt   <= '0;
            h_period   <= '0;
            h_width    <= '0;
            v_lines    <= '0;
            v_width    <= '0;
            frame_sum  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            {hs_r, vs_r, pix} <= {hsync, vsync, red, green, blue};
            hs_p       <= hs_r;
            vs_p       <= vs_r;
            hcnt       <= hpos;
            vcnt       <= vpos;
            hw_cnt     <= h_lead ? 11'd1 : h_act ? inc(hw_cnt) : hw_cnt;
            vw_cnt     <= v_lead ? {10'd0, h_lead} : (v_act && h_lead) ? inc(vw_cnt) : vw_cnt;
            sum        <= v_lead ? '0 : win ? sum + {16'd0, pix} : sum;
            line_err   <= !v_lead && (line_err || line_bad);
            h_valid    <= !timeout && (h_valid || h_lead);
            frame_done <= frame_end;
            frame_err  <= frame_end && !good;
            if (h_trail) h_width <= hw_cnt;
            if (h_lead && h_valid) h_period <= hinc;
            if (frame_end) begin
                v_lines   <= vinc;
                v_width   <= vw_cnt;
                frame_sum <= sum;
                good_cnt  <= good ? gc_inc : '0;
                locked    <= good && (locked || gc_inc >= LF);
            end
            if (timeout || (state == SEARCH && v_lead)) begin
                good_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed frames on a scaled-down raster with hand-derived
// expectations for measurements, lock, error pulses, timeout and mid-frame reset.
module tb_vga_timing_monitor;
    localparam int HT = 40, HS = 6, HAS = 10, HA = 24;
    localparam int VT = 20, VS = 2, VAS = 4, VA = 12;
    localparam logic [23:0] SUM_FF = 24'(HA * VA * 255);

    logic        clk25 = 1'b0, clr_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0]  red = '0, green = '0;
    logic [1:0]  blue = '0;
    logic [10:0] h_period, h_width, v_lines, v_width;
    logic [23:0] frame_sum;
    logic        frame_done, frame_err, locked;
    logic [70:0] outs;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACTIVE(VA),
        .SYNC_POL(0), .LOCK_FRAMES(2)
    ) dut (
        .clk25(clk25), .clr_n(clr_n), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .h_period(h_period), .h_width(h_width), .v_lines(v_lines), .v_width(v_width),
        .frame_sum(frame_sum), .frame_done(frame_done), .frame_err(frame_err), .locked(locked)
    );

    assign outs = {h_period, h_width, v_lines, v_width, frame_sum, frame_done, frame_err, locked};

    always #5 clk25 = ~clk25;

    int errors = 0, checks = 0, nfd = 0, cur_frame = -1;
    logic [10:0] log_hp[16], log_hw[16], log_vl[16], log_vw[16];
    logic [23:0] log_sum[16];
    logic        log_err[16], log_lock[16];
    int          log_frame[16];

    always @(negedge clk25) begin
        if (frame_done) begin
            if (nfd < 16) begin
                log_hp[nfd]    = h_period;
                log_hw[nfd]    = h_width;
                log_vl[nfd]    = v_lines;
                log_vw[nfd]    = v_width;
                log_sum[nfd]   = frame_sum;
                log_err[nfd]   = frame_err;
                log_lock[nfd]  = locked;
                log_frame[nfd] = cur_frame;
            end
            nfd = nfd + 1;
        end
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int x, input int y);
        return 8'(x * 3 + y * 7);
    endfunction

    function automatic logic [7:0] col(input int x, input int y, input int mode);
        if (!(x >= HAS && x < HAS + HA && y >= VAS && y < VAS + VA)) return 8'h00;
        return mode == 1 ? 8'hFF : mode == 2 ? pat(x, y) : 8'h00;
    endfunction

    function automatic logic [23:0] pat_sum();
        logic [23:0] s;
        s = '0;
        for (int y = VAS; y < VAS + VA; y++)
            for (int x = HAS; x < HAS + HA; x++)
                s = s + 24'(pat(x, y));
        return s;
    endfunction

    task automatic drive(input logic h, input logic v, input logic [7:0] p);
        @(negedge clk25);
        hsync = h;
        vsync = v;
        {red, green, blue} = p;
    endtask

    task automatic gen_lines(input int y0, input int y1, input int mode, input int long_y);
        for (int y = y0; y < y1; y++)
            for (int x = 0; x < HT + (y == long_y ? 1 : 0); x++)
                drive(x >= HS, y >= VS, col(x, y, mode));
    endtask

    task automatic frame(input int mode, input int long_y, input int y1);
        cur_frame = cur_frame + 1;
        gen_lines(0, y1, mode, long_y);
    endtask

    int exp_lock[11]  = '{0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 1};
    int exp_frame[11] = '{1, 2, 3, 4, 5, 6, 7, 9, 10, 12, 13};

    initial begin
        int n0;
        logic [23:0] es;
        // reset held while the sync inputs toggle randomly
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            if (i % 8 == 7) check("reset_outs", 72'(outs), 72'(0));
        end
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        clr_n = 1'b1;
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        check("idle_after_rst", 72'(outs), 72'(0));
        frame(1, -1, VT);
        frame(1, -1, VT);
        frame(1, -1, VT);
        frame(2, -1, VT);
        frame(1, 8, VT);
        frame(0, -1, VT);
        frame(1, -1, VT);
        frame(1, -1, 5);
        check("locked_before_to", 72'(locked), 72'(1));
        n0 = nfd;
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 8'h00);
        check("to_not_yet", 72'(locked), 72'(1));
        for (int i = 0; i < 3 * HT; i++) drive(1'b1, 1'b1, 8'h00);
        check("to_unlocked", 72'(locked), 72'(0));
        check("to_no_done", 72'(nfd), 72'(n0));
        check("to_hp_held", 72'(h_period), 72'(HT));
        check("to_vl_held", 72'(v_lines), 72'(VT));
        check("to_sum_held", 72'(frame_sum), 72'(SUM_FF));
        frame(1, -1, VT);
        frame(1, -1, VT);
        cur_frame = cur_frame + 1;
        gen_lines(0, 8, 1, -1);
        check("locked_before_rst", 72'(locked), 72'(1));
        #2 clr_n = 1'b0;
        #1 check("rst_mid_outs", 72'(outs), 72'(0));
        gen_lines(8, 9, 1, -1);
        check("rst_hold_outs", 72'(outs), 72'(0));
        clr_n = 1'b1;
        gen_lines(9, VT, 1, -1);
        frame(1, -1, VT);
        frame(1, -1, VT);
        frame(1, -1, 3);
        check("done_count", 72'(nfd), 72'(11));
        for (int p = 0; p < 11; p++) begin
            es = p == 3 ? pat_sum() : p == 5 ? 24'h0 : SUM_FF;
            check($sformatf("p%0d_frame", p), 72'(log_frame[p]), 72'(exp_frame[p]));
            check($sformatf("p%0d_hper", p), 72'(log_hp[p]), 72'(HT));
            check($sformatf("p%0d_hwid", p), 72'(log_hw[p]), 72'(HS));
            check($sformatf("p%0d_vlines", p), 72'(log_vl[p]), 72'(VT));
            check($sformatf("p%0d_vwid", p), 72'(log_vw[p]), 72'(VS));
            check($sformatf("p%0d_sum", p), 72'(log_sum[p]), 72'(es));
            check($sformatf("p%0d_err", p), 72'(log_err[p]), 72'(p == 4 ? 1 : 0));
            check($sformatf("p%0d_lock", p), 72'(log_lock[p]), 72'(exp_lock[p]));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
